// File: rtl/dd_incoming_ctrl.sv
// dd_incoming_ctrl: 3-stage read/capture/writeback sequencer for per-flow ACK contexts
// with same-flow forwarding so every event sees the context in arrival order.
module dd_incoming_ctrl #(
  parameter int FLOW_ID_W = 10,
  parameter int SEQ_W     = 32,
  parameter int WIN_SIZE  = 128,
  parameter int IND_W     = 8,
  parameter int WSZ_W     = 8,
  parameter int PKT_W     = 4,
  parameter int TX_W      = 4,
  localparam int CTX_W    = WIN_SIZE + IND_W + SEQ_W + WSZ_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_val,
  output logic                 in_rdy,
  input  logic [FLOW_ID_W-1:0] in_flow_id,
  input  logic [PKT_W-1:0]     in_pkt_type,
  input  logic [SEQ_W-1:0]     in_cack,
  input  logic [SEQ_W-1:0]     in_sack,
  input  logic [TX_W-1:0]      in_sack_tx_id,
  input  logic                 cfg_val,
  output logic                 cfg_rdy,
  input  logic [FLOW_ID_W-1:0] cfg_flow_id,
  input  logic [SEQ_W-1:0]     cfg_wnd_start,
  input  logic [WSZ_W-1:0]     cfg_wnd_size,
  output logic                 ctx_rd_en,
  output logic [FLOW_ID_W-1:0] ctx_rd_addr,
  input  logic [CTX_W-1:0]     ctx_rd_data,
  output logic                 ctx_wr_en,
  output logic [FLOW_ID_W-1:0] ctx_wr_addr,
  output logic [CTX_W-1:0]     ctx_wr_data,
  output logic [PKT_W-1:0]     dp_pkt_type,
  output logic [SEQ_W-1:0]     dp_cack,
  output logic [SEQ_W-1:0]     dp_sack,
  output logic [TX_W-1:0]      dp_sack_tx_id,
  output logic [CTX_W-1:0]     dp_ctx,
  input  logic                 dp_valid_sack,
  input  logic [IND_W-1:0]     dp_new_c_acks_cnt,
  input  logic [WIN_SIZE-1:0]  dp_acked_wnd,
  input  logic [IND_W-1:0]     dp_wnd_start_ind,
  input  logic [SEQ_W-1:0]     dp_wnd_start,
  output logic                 out_val,
  input  logic                 out_rdy,
  output logic [FLOW_ID_W-1:0] out_flow_id,
  output logic                 out_valid_sack,
  output logic [IND_W-1:0]     out_new_c_acks_cnt,
  output logic [31:0]          stat_evt_cnt,
  output logic [31:0]          stat_sack_cnt
);
  // cfg ops reuse cack for the initial window start and wsz for the window size
  typedef struct packed {
    logic                 is_cfg;
    logic [FLOW_ID_W-1:0] flow;
    logic [PKT_W-1:0]     pkt;
    logic [SEQ_W-1:0]     cack;
    logic [SEQ_W-1:0]     sack;
    logic [TX_W-1:0]      tx;
    logic [WSZ_W-1:0]     wsz;
  } op_t;

  logic s1_val_q, s1_val_d, s1_first_q, s1_first_d, s2_val_q, s2_val_d, wr1_val_q, wr1_val_d;
  op_t s1_op_q, s1_op_d, s2_op_q, s2_op_d, acc_op;
  logic [CTX_W-1:0] s1_hold_q, s1_hold_d, s2_ctx_q, s2_ctx_d, wr1_data_q, wr1_data_d, s1_raw, s1_ctx;
  logic [FLOW_ID_W-1:0] wr1_addr_q, wr1_addr_d;
  logic [31:0] stat_evt_cnt_q, stat_evt_cnt_d, stat_sack_cnt_q, stat_sack_cnt_d;
  logic s1_adv, s1_free, acc_cfg, acc_evt, s2_cfg, retire;

  always_comb begin
    s2_cfg = s2_val_q & s2_op_q.is_cfg;
    s1_adv = ~s2_val_q | s2_op_q.is_cfg | out_rdy;
    s1_free = ~s1_val_q | s1_adv;
    cfg_rdy = s1_free & ~rst;
    in_rdy = cfg_rdy & ~cfg_val;
    acc_cfg = cfg_val & cfg_rdy;
    acc_evt = in_val & in_rdy;
    ctx_rd_en = acc_evt;
    ctx_rd_addr = acc_evt ? in_flow_id : '0;
    out_val = s2_val_q & ~s2_op_q.is_cfg;
    retire = out_val & out_rdy;
    ctx_wr_en = retire | s2_cfg;
    ctx_wr_addr = ctx_wr_en ? s2_op_q.flow : '0;
  end

  // A write issued last cycle raced the RAM read (old data returned), a write this
  // cycle has not reached the RAM yet; both must override what S1 holds.
  always_comb begin
    ctx_wr_data = s2_cfg ? {{(WIN_SIZE + IND_W){1'b0}}, s2_op_q.cack, s2_op_q.wsz}
                : retire ? {dp_acked_wnd, dp_wnd_start_ind, dp_wnd_start, s2_ctx_q[WSZ_W-1:0]}
                : '0;
    s1_raw = !s1_first_q ? s1_hold_q
           : (wr1_val_q && wr1_addr_q == s1_op_q.flow) ? wr1_data_q : ctx_rd_data;
    s1_ctx = (ctx_wr_en && ctx_wr_addr == s1_op_q.flow) ? ctx_wr_data : s1_raw;
    out_valid_sack = out_val & dp_valid_sack;
    out_new_c_acks_cnt = out_val ? dp_new_c_acks_cnt : '0;
  end

  assign dp_pkt_type   = s2_op_q.pkt;
  assign dp_cack       = s2_op_q.cack;
  assign dp_sack       = s2_op_q.sack;
  assign dp_sack_tx_id = s2_op_q.tx;
  assign dp_ctx        = s2_ctx_q;
  assign out_flow_id   = s2_op_q.flow;
  assign stat_evt_cnt  = stat_evt_cnt_q;
  assign stat_sack_cnt = stat_sack_cnt_q;

  always_comb begin
    acc_op = '0;
    acc_op.is_cfg = acc_cfg;
    acc_op.flow = acc_cfg ? cfg_flow_id : in_flow_id;
    acc_op.pkt = in_pkt_type;
    acc_op.cack = acc_cfg ? cfg_wnd_start : in_cack;
    acc_op.sack = in_sack;
    acc_op.tx = in_sack_tx_id;
    acc_op.wsz = cfg_wnd_size;
    s1_val_d = s1_free ? (acc_cfg | acc_evt) : s1_val_q;
    s1_first_d = s1_free & (acc_cfg | acc_evt);
    s1_op_d = s1_free ? acc_op : s1_op_q;
    s1_hold_d = s1_val_q ? s1_ctx : s1_hold_q;
    s2_val_d = s1_adv ? s1_val_q : s2_val_q;
    s2_op_d = s1_adv ? s1_op_q : s2_op_q;
    s2_ctx_d = s1_adv ? s1_ctx : s2_ctx_q;
    wr1_val_d = ctx_wr_en;
    wr1_addr_d = ctx_wr_addr;
    wr1_data_d = ctx_wr_data;
    stat_evt_cnt_d = stat_evt_cnt_q + 32'(retire);
    stat_sack_cnt_d = stat_sack_cnt_q + 32'(retire & dp_valid_sack);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_val_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_op_q <= '0;
      s1_hold_q <= '0;
      s2_val_q <= 1'b0;
      s2_op_q <= '0;
      s2_ctx_q <= '0;
      wr1_val_q <= 1'b0;
      wr1_addr_q <= '0;
      wr1_data_q <= '0;
      stat_evt_cnt_q <= '0;
      stat_sack_cnt_q <= '0;
    end else begin
      s1_val_q <= s1_val_d;
      s1_first_q <= s1_first_d;
      s1_op_q <= s1_op_d;
      s1_hold_q <= s1_hold_d;
      s2_val_q <= s2_val_d;
      s2_op_q <= s2_op_d;
      s2_ctx_q <= s2_ctx_d;
      wr1_val_q <= wr1_val_d;
      wr1_addr_q <= wr1_addr_d;
      wr1_data_q <= wr1_data_d;
      stat_evt_cnt_q <= stat_evt_cnt_d;
      stat_sack_cnt_q <= stat_sack_cnt_d;
    end
  end
endmodule
